// File: rtl/chunked_adder_seq.sv
// chunked_adder_seq: multi-cycle wide adder, one N-bit chunk per clock with a carry register
module chunked_adder_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic [N:0]      chunk;
  logic            last;
  assign chunk    = {1'b0, a_q[idx_q*N +: N]} + {1'b0, b_q[idx_q*N +: N]} + {{N{1'b0}}, c_q};
  assign last     = idx_q == IW'(WORDS - 1);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;
  // state and datapath registers, reset has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // next state: start accepted only in IDLE, RUN ends after the last chunk
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end
  // registered status outputs follow the next state so they line up with it
  always_comb begin
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  // operand capture on accept, one chunk written per RUN cycle
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    idx_d  = idx_q;
    c_d    = c_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (state_q == IDLE && start) begin
      a_d    = a;
      b_d    = b;
      sum_d  = '0;
      idx_d  = '0;
      c_d    = 1'b0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (state_q == RUN) begin
      sum_d[idx_q*N +: N] = chunk[N-1:0];
      c_d   = chunk[N];
      idx_d = idx_q + 1'b1;
      if (last) begin
        cout_d = chunk[N];
        ovf_d  = (a_q[W-1] & b_q[W-1] & ~chunk[N-1]) | (~a_q[W-1] & ~b_q[W-1] & chunk[N-1]);
      end
    end
  end
endmodule

// File: tb/tb_chunked_adder_seq.sv
// tb_chunked_adder_seq: directed and random checks of chunked_adder_seq against an arithmetic model
module tb_chunked_adder_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a_i = '0, b_i = '0;
  logic [15:0] sum;
  logic        cout, overflow, busy, done;
  int          n_chk = 0, n_fail = 0;

  chunked_adder_seq #(.N(4), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: plain add, 1: stray start during RUN, 2: reset during RUN
  task automatic run_add(input logic [15:0] x, input logic [15:0] y, input int mode);
    logic [16:0] r;
    logic        ov;
    int          n;
    bit          seen;
    r  = {1'b0, x} + {1'b0, y};
    ov = (x[15] == y[15]) && (r[15] != x[15]);
    a_i = x; b_i = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    seen = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      seen = done;
      if (mode == 1 && n == 1) begin start = 1'b1; a_i = '1; b_i = '1; end
      if (mode == 1 && n == 2) start = 1'b0;
      if (mode == 2 && n == 1) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (6) begin
          @(negedge clk);
          chk("no_done_after_rst", 32'(done), 32'd0);
        end
        return;
      end
    end
    chk("latency", 32'(n), 32'd4);
    chk("sum", 32'(sum), 32'(r[15:0]));
    chk("cout", 32'(cout), 32'(r[16]));
    chk("ovf", 32'(overflow), 32'(ov));
    chk("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
    chk("sum_hold", 32'(sum), 32'(r[15:0]));
    if (mode == 1)
      repeat (4) begin
        @(negedge clk);
        chk("single_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
      end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_add(16'h00FF, 16'h0001, 0);
    run_add(16'hFFFF, 16'h0001, 0);
    run_add(16'h7FFF, 16'h0001, 0);
    run_add(16'h8000, 16'h8000, 0);
    run_add(16'h1234, 16'h4321, 0);
    run_add(16'h1111, 16'h2222, 1);
    run_add(16'hFFFF, 16'h0001, 2);
    run_add(16'h0003, 16'h0004, 0);
    for (int i = 0; i < 25; i++) begin
      run_add(16'($urandom), 16'($urandom), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
